// File: rtl/ternary_pkg.sv
// Shared types and helpers for the ternary weight loader.
package ternary_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Ternary weight encoding; the reserved code is stored and passed through untouched.
  localparam logic [1:0] TERN_ZERO = 2'b00;
  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_NEG  = 2'b11;
  localparam logic [1:0] TERN_RSVD = 2'b10;

  // Bit offset of weight (o, i) inside a flattened bank.
  function automatic int weight_offset(input int o, input int i, input int in_len,
                                       input int width);
    return (o * in_len + i) * width;
  endfunction

endpackage

// File: rtl/ternary_weight_loader_bank.sv
// Double-buffered weight storage: active bank drives the read port, the other
// bank (shadow) takes column writes or a full clear, and swap flips the roles.
module weight_bank_pair
  import ternary_pkg::*;
#(
  parameter int IN_LEN   = 16,
  parameter int OUT_LEN  = 8,
  parameter int WIDTH    = 2,
  parameter int OUT_BITS = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        wr_en,
  input  logic [OUT_BITS-1:0]         wr_col,
  input  logic [WIDTH*IN_LEN-1:0]     wr_data,
  input  logic                        swap,
  output logic [WIDTH*IN_LEN*OUT_LEN-1:0] rd_data
);

  localparam int COL_W   = WIDTH * IN_LEN;
  localparam int W_TOTAL = COL_W * OUT_LEN;

  logic [W_TOTAL-1:0] bank0_q, bank0_d;
  logic [W_TOTAL-1:0] bank1_q, bank1_d;
  logic [W_TOTAL-1:0] shadow;
  logic               sel_q, sel_d;
  int                 wr_base;

  assign wr_base = weight_offset(int'(wr_col), 0, IN_LEN, WIDTH);

  // Update the shadow bank (clear has priority over a column write) and flip on swap.
  always_comb begin
    bank0_d = bank0_q;
    bank1_d = bank1_q;
    sel_d   = sel_q ^ swap;
    shadow  = sel_q ? bank0_q : bank1_q;
    if (clr) begin
      shadow = '0;
    end else if (wr_en) begin
      shadow[wr_base +: COL_W] = wr_data;
    end
    if (sel_q) begin
      bank0_d = shadow;
    end else begin
      bank1_d = shadow;
    end
  end

  // Bank and select registers; reset zeroes both banks including the active one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0_q <= '0;
      bank1_q <= '0;
      sel_q   <= 1'b0;
    end else begin
      bank0_q <= bank0_d;
      bank1_q <= bank1_d;
      sel_q   <= sel_d;
    end
  end

  assign rd_data = sel_q ? bank1_q : bank0_q;

endmodule

// File: rtl/ternary_weight_loader.sv
// Column-at-a-time weight loader with atomic shadow/active bank swap.
module ternary_weight_loader
  import ternary_pkg::*;
#(
  parameter int IN_LEN    = 16,
  parameter int OUT_LEN   = 8,
  parameter int WIDTH     = 2,
  parameter int ZERO_FILL = 1,
  parameter int OUT_BITS  = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1,
  parameter int W_TOTAL   = WIDTH * IN_LEN * OUT_LEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    start,
  input  logic [OUT_BITS-1:0]     cfg_last_col,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WIDTH*IN_LEN-1:0] s_data,
  output logic [W_TOTAL-1:0]      uo_weights,
  output logic                    uo_busy,
  output logic                    uo_done,
  output logic                    uo_abort
);

  state_t              state_q, state_d;
  logic [OUT_BITS-1:0] col_q, col_d;
  logic [OUT_BITS-1:0] last_col_q, last_col_d;
  logic                done_q, done_d;
  logic                abort_q, abort_d;
  logic [OUT_BITS-1:0] cfg_clamped;
  logic                bank_clr, bank_wr, bank_swap;

  // Column counts beyond the array (non-power-of-two OUT_LEN) collapse to the last column.
  assign cfg_clamped = (int'(cfg_last_col) > OUT_LEN - 1) ? OUT_BITS'(OUT_LEN - 1)
                                                           : cfg_last_col;

  // Next-state, counters and bank controls; everything holds while ena is low.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    last_col_d = last_col_q;
    done_d     = done_q;
    abort_d    = abort_q;
    bank_clr   = 1'b0;
    bank_wr    = 1'b0;
    bank_swap  = 1'b0;
    s_ready    = 1'b0;
    if (ena) begin
      done_d  = (state_q == COMMIT);
      abort_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = LOAD;
            col_d      = '0;
            last_col_d = cfg_clamped;
            bank_clr   = (ZERO_FILL != 0);
          end
        end
        LOAD: begin
          s_ready = 1'b1;
          // A restart wins over a beat presented in the same cycle.
          if (start) begin
            col_d      = '0;
            last_col_d = cfg_clamped;
            bank_clr   = (ZERO_FILL != 0);
            abort_d    = 1'b1;
          end else if (s_valid) begin
            bank_wr = 1'b1;
            if (col_q == last_col_q) begin
              state_d = COMMIT;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
        COMMIT: begin
          bank_swap = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      last_col_q <= '0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      last_col_q <= last_col_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  weight_bank_pair #(
    .IN_LEN  (IN_LEN),
    .OUT_LEN (OUT_LEN),
    .WIDTH   (WIDTH),
    .OUT_BITS(OUT_BITS)
  ) u_banks (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (bank_clr),
    .wr_en  (bank_wr),
    .wr_col (col_q),
    .wr_data(s_data),
    .swap   (bank_swap),
    .rd_data(uo_weights)
  );

  // Pending pulses only become visible on a cycle where the block is enabled.
  assign uo_busy  = (state_q != IDLE);
  assign uo_done  = done_q & ena;
  assign uo_abort = abort_q & ena;

endmodule

// File: tb/tb_ternary_weight_loader.sv
// Directed bench for ternary_weight_loader (ZERO_FILL=1 main, ZERO_FILL=0 companion).
module tb_ternary_weight_loader;
  import ternary_pkg::*;

  localparam int IN_LEN   = 16;
  localparam int OUT_LEN  = 8;
  localparam int WIDTH    = 2;
  localparam int OUT_BITS = 3;
  localparam int COL_W    = WIDTH * IN_LEN;
  localparam int W_TOTAL  = COL_W * OUT_LEN;
  localparam logic [W_TOTAL-1:0] W0 = '0;
  localparam logic [W_TOTAL-1:0] W1 = W_TOTAL'(1);

  logic                clk = 1'b0;
  logic                rst_n, ena, start, s_valid;
  logic [OUT_BITS-1:0] cfg_last_col;
  logic [COL_W-1:0]    s_data;
  logic                s_ready, uo_busy, uo_done, uo_abort;
  logic [W_TOTAL-1:0]  uo_weights;
  logic                z_s_ready, z_busy, z_done, z_abort;
  logic [W_TOTAL-1:0]  z_weights;

  int checks   = 0;
  int failures = 0;
  logic [W_TOTAL-1:0] exp_w, prev_w, exp_z;

  always #5 clk = ~clk;

  ternary_weight_loader #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .WIDTH(WIDTH), .ZERO_FILL(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cfg_last_col(cfg_last_col),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .uo_weights(uo_weights),
    .uo_busy(uo_busy), .uo_done(uo_done), .uo_abort(uo_abort)
  );

  ternary_weight_loader #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .WIDTH(WIDTH), .ZERO_FILL(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cfg_last_col(cfg_last_col),
    .s_valid(s_valid), .s_ready(z_s_ready), .s_data(s_data), .uo_weights(z_weights),
    .uo_busy(z_busy), .uo_done(z_done), .uo_abort(z_abort)
  );

  task automatic chk(input string tag, input logic [W_TOTAL-1:0] act,
                     input logic [W_TOTAL-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [COL_W-1:0] col_rep(input logic [1:0] v);
    return {IN_LEN{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [OUT_BITS-1:0] last);
    start        = 1'b1;
    cfg_last_col = last;
    tick();
    start        = 1'b0;
  endtask

  task automatic beat(input logic [COL_W-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  // Called in the cycle right after the last accepted beat (COMMIT).
  task automatic finish_commit(input string tag, input logic [W_TOTAL-1:0] exp,
                               input logic [W_TOTAL-1:0] old);
    chk({tag, "_commit_done"}, W_TOTAL'(uo_done), W0);
    chk({tag, "_commit_w"}, uo_weights, old);
    chk({tag, "_commit_ready"}, W_TOTAL'(s_ready), W0);
    chk({tag, "_commit_busy"}, W_TOTAL'(uo_busy), W1);
    tick();
    chk({tag, "_done"}, W_TOTAL'(uo_done), W1);
    chk({tag, "_w"}, uo_weights, exp);
    chk({tag, "_idle_busy"}, W_TOTAL'(uo_busy), W0);
    chk({tag, "_idle_ready"}, W_TOTAL'(s_ready), W0);
    tick();
    chk({tag, "_done_clr"}, W_TOTAL'(uo_done), W0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; s_valid = 1'b0;
    s_data = '0; cfg_last_col = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w", uo_weights, W0);
    chk("rst_ready", W_TOTAL'(s_ready), W0);
    chk("rst_busy", W_TOTAL'(uo_busy), W0);
    chk("rst_done", W_TOTAL'(uo_done), W0);
    chk("rst_abort", W_TOTAL'(uo_abort), W0);
    chk("rst_z_w", z_weights, W0);
    chk("rst_z_ctl", W_TOTAL'({z_s_ready, z_busy, z_done, z_abort}), W0);
    rst_n = 1'b1;
    tick();

    // Basic full load: column o holds 16 copies of o[1:0].
    start_load(3'd7);
    chk("t1_busy", W_TOTAL'(uo_busy), W1);
    chk("t1_ready", W_TOTAL'(s_ready), W1);
    exp_w = '0;
    for (int o = 0; o < 8; o++) begin
      beat(col_rep(2'(o)));
      exp_w[o*COL_W +: COL_W] = col_rep(2'(o));
      if (o < 7) chk("t1_w_pre", uo_weights, W0);
    end
    finish_commit("t1", exp_w, W0);

    // Two full loads of +1 so both banks hold +1, then a partial load of -1.
    prev_w = exp_w;
    for (int k = 0; k < 2; k++) begin
      start_load(3'd7);
      for (int o = 0; o < 8; o++) beat(col_rep(TERN_POS));
      finish_commit("t2_full", {OUT_LEN{col_rep(TERN_POS)}}, prev_w);
      prev_w = {OUT_LEN{col_rep(TERN_POS)}};
    end
    start_load(3'd2);
    for (int o = 0; o < 3; o++) beat(col_rep(TERN_NEG));
    exp_w = {{5{col_rep(TERN_ZERO)}}, {3{col_rep(TERN_NEG)}}};
    exp_z = {{5{col_rep(TERN_POS)}}, {3{col_rep(TERN_NEG)}}};
    finish_commit("t2_part", exp_w, prev_w);
    chk("t2_nozero_w", z_weights, exp_z);

    // Valid gaps: pattern 1,0,0 per beat; includes reserved codes in the data.
    prev_w = exp_w;
    start_load(3'd7);
    chk("t3_busy", W_TOTAL'(uo_busy), W1);
    for (int o = 0; o < 8; o++) begin
      beat(COL_W'((o + 1) * 32'h1111_1111));
      exp_w[o*COL_W +: COL_W] = COL_W'((o + 1) * 32'h1111_1111);
      if (o < 7) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          chk("t3_gap_busy", W_TOTAL'(uo_busy), W1);
          chk("t3_gap_ready", W_TOTAL'(s_ready), W1);
        end
        chk("t3_w_pre", uo_weights, prev_w);
      end
    end
    finish_commit("t3", exp_w, prev_w);

    // Abort after 4 beats; the restart cycle also presents a beat that must be dropped.
    prev_w = exp_w;
    start_load(3'd7);
    for (int o = 0; o < 4; o++) beat(col_rep(TERN_NEG));
    start = 1'b1; cfg_last_col = 3'd7; s_valid = 1'b1; s_data = '1;
    tick();
    start = 1'b0; s_valid = 1'b0;
    chk("t4_abort", W_TOTAL'(uo_abort), W1);
    chk("t4_abort_w", uo_weights, prev_w);
    tick();
    chk("t4_abort_clr", W_TOTAL'(uo_abort), W0);
    for (int o = 0; o < 8; o++) begin
      beat(32'h0F0F_0F0F ^ COL_W'(o * 32'h1111_1111));
      exp_w[o*COL_W +: COL_W] = 32'h0F0F_0F0F ^ COL_W'(o * 32'h1111_1111);
      if (o == 3) chk("t4_w_mid", uo_weights, prev_w);
    end
    finish_commit("t4", exp_w, prev_w);
    chk("t4_abort_once", W_TOTAL'(uo_abort), W0);

    // ena low for 5 cycles mid-load with valid and start asserted.
    prev_w = exp_w;
    start_load(3'd7);
    for (int o = 0; o < 3; o++) begin
      beat(32'hA5A5_0000 | COL_W'(o));
      exp_w[o*COL_W +: COL_W] = 32'hA5A5_0000 | COL_W'(o);
    end
    ena = 1'b0; s_valid = 1'b1; s_data = '1; start = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("t5_frz_ready", W_TOTAL'(s_ready), W0);
      chk("t5_frz_busy", W_TOTAL'(uo_busy), W1);
    end
    ena = 1'b1; s_valid = 1'b0; start = 1'b0;
    chk("t5_no_abort", W_TOTAL'(uo_abort), W0);
    for (int o = 3; o < 8; o++) begin
      beat(32'hA5A5_0000 | COL_W'(o));
      exp_w[o*COL_W +: COL_W] = 32'hA5A5_0000 | COL_W'(o);
    end
    finish_commit("t5", exp_w, prev_w);

    // Asynchronous reset between edges, then a single-column load.
    start_load(3'd7);
    beat(32'hDEAD_BEEF);
    beat(32'hCAFE_F00D);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_w", uo_weights, W0);
    chk("t6_rst_ready", W_TOTAL'(s_ready), W0);
    chk("t6_rst_busy", W_TOTAL'(uo_busy), W0);
    chk("t6_rst_z_w", z_weights, W0);
    tick();
    rst_n = 1'b1;
    tick();
    start_load(3'd0);
    chk("t6_busy", W_TOTAL'(uo_busy), W1);
    beat(32'h1234_5678);
    exp_w = '0;
    exp_w[COL_W-1:0] = 32'h1234_5678;
    finish_commit("t6", exp_w, W0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
